// File: rtl/imm_arbiter_if.sv
// Handshake bundle between two instruction requesters, the shared immediate
// generator and the result consumer of imm_arbiter.
interface imm_arbiter_if #(
    parameter int W = 32
);
    logic         req0_valid;
    logic [W-1:0] req0_instr;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_instr;
    logic         req1_ready;
    logic [W-1:0] gen_instr;
    logic [W-1:0] gen_imm;
    logic         out_valid;
    logic [W-1:0] out_imm;
    logic         out_src;
    logic         out_err;
    logic         out_ready;

    modport master (
        output req0_valid, req0_instr, req1_valid, req1_instr, gen_imm, out_ready,
        input  req0_ready, req1_ready, gen_instr, out_valid, out_imm, out_src, out_err
    );

    modport slave (
        input  req0_valid, req0_instr, req1_valid, req1_instr, gen_imm, out_ready,
        output req0_ready, req1_ready, gen_instr, out_valid, out_imm, out_src, out_err
    );
endinterface

// File: rtl/imm_arbiter.sv
// Round-robin arbiter sharing one immediate generator between two requesters,
// with a registered result held until the consumer takes it.
module imm_arbiter #(
    parameter int W     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    imm_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] instr_q;
    logic         src_q;
    logic         last_grant;
    logic         grant0;
    logic         grant1;
    logic [W-1:0] out_imm_q;
    logic         out_src_q;
    logic         out_err_q;

    // Grants only happen in IDLE; a tie goes to whoever was not granted last.
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (bus.req0_valid || bus.req1_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            src_q      <= 1'b0;
            last_grant <= 1'b1;
            out_imm_q  <= '0;
            out_src_q  <= 1'b0;
            out_err_q  <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state_q <= state_d;
            if (grant0) begin
                instr_q    <= bus.req0_instr;
                src_q      <= 1'b0;
                last_grant <= 1'b0;
                if (grant_cnt0 != {CNT_W{1'b1}}) begin
                    grant_cnt0 <= grant_cnt0 + 1'b1;
                end
            end else if (grant1) begin
                instr_q    <= bus.req1_instr;
                src_q      <= 1'b1;
                last_grant <= 1'b1;
                if (grant_cnt1 != {CNT_W{1'b1}}) begin
                    grant_cnt1 <= grant_cnt1 + 1'b1;
                end
            end
            if (state_q == ISSUE) begin
                out_imm_q <= bus.gen_imm;
                out_src_q <= src_q;
                out_err_q <= (instr_q[1:0] != 2'b11);
            end
        end
    end

    // Reset masks the combinational grants so nothing is accepted mid-reset.
    assign bus.req0_ready = grant0 && !rst;
    assign bus.req1_ready = grant1 && !rst;
    assign bus.gen_instr  = instr_q;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_imm    = out_imm_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_err    = out_err_q;
    assign busy           = (state_q != IDLE) && !rst;
endmodule

// File: tb/tb_imm_arbiter.sv
// Directed bench for imm_arbiter with an I-type immediate model standing in
// for the shared generator; counters are 2 bits wide to reach saturation.
module tb_imm_arbiter;
    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] cnt0;
    logic [1:0] cnt1;
    int         checks;
    int         errors;

    imm_arbiter_if #(.W(32)) bus ();

    imm_arbiter #(.W(32), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .grant_cnt0 (cnt0),
        .grant_cnt1 (cnt1)
    );

    assign bus.gen_imm = {{20{bus.gen_instr[31]}}, bus.gen_instr[31:20]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] i0,
                                 input logic v1, input logic [31:0] i1,
                                 input logic ordy);
        bus.req0_valid = v0;
        bus.req0_instr = i0;
        bus.req1_valid = v1;
        bus.req1_instr = i1;
        bus.out_ready  = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic expsrc;
        checks = 0;
        errors = 0;

        // Reset with both requesters pushing: nothing may be accepted.
        rst = 1'b1;
        applyStimulus(1'b1, 32'h00500093, 1'b1, 32'h00300013, 1'b1);
        step();
        step();
        checkOutput("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        checkOutput("rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_cnt0", {30'b0, cnt0}, 32'd0);
        checkOutput("rst_cnt1", {30'b0, cnt1}, 32'd0);
        checkOutput("rst_gen_instr", bus.gen_instr, 32'd0);
        checkOutput("rst_out_imm", bus.out_imm, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        step();

        // Single request from requester 0: addi x1,x0,5.
        applyStimulus(1'b1, 32'h00500093, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("single_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
        checkOutput("single_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        step();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("issue_busy", {31'b0, busy}, 32'd1);
        checkOutput("issue_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        checkOutput("issue_gen_instr", bus.gen_instr, 32'h00500093);
        checkOutput("issue_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("single_cnt0", {30'b0, cnt0}, 32'd1);
        step();
        checkOutput("single_out_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("single_out_imm", bus.out_imm, 32'h00000005);
        checkOutput("single_out_src", {31'b0, bus.out_src}, 32'd0);
        checkOutput("single_out_err", {31'b0, bus.out_err}, 32'd0);
        step();
        checkOutput("single_after_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("single_after_busy", {31'b0, busy}, 32'd0);

        // Backpressure on an erroneous requester-1 instruction.
        applyStimulus(1'b0, 32'd0, 1'b1, 32'hFFF00001, 1'b0);
        #1;
        checkOutput("bp_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
        checkOutput("bp_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        step();
        applyStimulus(1'b1, 32'h00500093, 1'b0, 32'd0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("bp_out_imm", bus.out_imm, 32'hFFFFFFFF);
            checkOutput("bp_out_src", {31'b0, bus.out_src}, 32'd1);
            checkOutput("bp_out_err", {31'b0, bus.out_err}, 32'd1);
            checkOutput("bp_req0_ready_held", {31'b0, bus.req0_ready}, 32'd0);
            checkOutput("bp_busy", {31'b0, busy}, 32'd1);
            step();
        end
        applyStimulus(1'b1, 32'h00500093, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("hs_cycle_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        step();
        checkOutput("hs_idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("hs_idle_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("hs_idle_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        #1;
        checkOutput("drop_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        step();
        checkOutput("drop_busy", {31'b0, busy}, 32'd0);
        checkOutput("drop_cnt0", {30'b0, cnt0}, 32'd1);
        checkOutput("bp_cnt1", {30'b0, cnt1}, 32'd1);

        // Non-32-bit encoding from requester 1 still delivers its immediate.
        applyStimulus(1'b0, 32'd0, 1'b1, 32'h00000001, 1'b1);
        #1;
        checkOutput("err_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
        step();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        step();
        checkOutput("err_out_err", {31'b0, bus.out_err}, 32'd1);
        checkOutput("err_out_src", {31'b0, bus.out_src}, 32'd1);
        checkOutput("err_out_imm", bus.out_imm, 32'h00000000);
        step();
        checkOutput("err_cnt1", {30'b0, cnt1}, 32'd2);

        // Continuous tie: requester 1 won last, so grants run 0,1,0,1.
        applyStimulus(1'b1, 32'h00700093, 1'b1, 32'h00300013, 1'b1);
        for (int r = 0; r < 4; r++) begin
            expsrc = r[0];
            #1;
            checkOutput("tie_req0_ready", {31'b0, bus.req0_ready}, {31'b0, !expsrc});
            checkOutput("tie_req1_ready", {31'b0, bus.req1_ready}, {31'b0, expsrc});
            step();
            checkOutput("tie_issue_ready", {30'b0, bus.req0_ready, bus.req1_ready}, 32'd0);
            step();
            checkOutput("tie_out_src", {31'b0, bus.out_src}, {31'b0, expsrc});
            checkOutput("tie_out_imm", bus.out_imm, expsrc ? 32'd3 : 32'd7);
            step();
        end
        checkOutput("tie_cnt0", {30'b0, cnt0}, 32'd3);
        checkOutput("tie_cnt1_sat", {30'b0, cnt1}, 32'd3);

        // Two more requester-0 grants make five in total; counter holds at 3.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 32'h00500093, 1'b0, 32'd0, 1'b1);
            step();
            applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
            step();
            step();
        end
        checkOutput("sat_cnt0", {30'b0, cnt0}, 32'd3);

        // Reset while holding a result in DONE discards it.
        applyStimulus(1'b1, 32'h00900093, 1'b0, 32'd0, 1'b0);
        step();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        step();
        checkOutput("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        checkOutput("pre_rst_imm", bus.out_imm, 32'd9);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h00700093, 1'b1, 32'h00300013, 1'b1);
        #1;
        checkOutput("inrst_ready", {30'b0, bus.req0_ready, bus.req1_ready}, 32'd0);
        checkOutput("inrst_busy", {31'b0, busy}, 32'd0);
        step();
        checkOutput("postrst_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("postrst_cnt0", {30'b0, cnt0}, 32'd0);
        checkOutput("postrst_cnt1", {30'b0, cnt1}, 32'd0);
        checkOutput("postrst_out_imm", bus.out_imm, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("postrst_tie_req0", {31'b0, bus.req0_ready}, 32'd1);
        checkOutput("postrst_tie_req1", {31'b0, bus.req1_ready}, 32'd0);
        step();
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        step();
        checkOutput("postrst_out_src", {31'b0, bus.out_src}, 32'd0);
        checkOutput("postrst_out_imm7", bus.out_imm, 32'd7);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
